// File: rtl/foo_call_driver_pkg.sv
// Shared types and default widths for the foo call driver slice.
package foo_call_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drv_state_e;

    localparam int ARG_W_DEF = 64;
    localparam int RET_W_DEF = 8;
    localparam int TAG_W_DEF = 8;

endpackage

// File: rtl/foo_drv_fifo.sv
// Synchronous FIFO exposing the head entry and the entry behind it, so the
// caller can present the next argument in the same cycle the head is popped.
module foo_drv_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_ptr_inc_s;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full         = (count_r == (AW+1)'(DEPTH));
    assign empty        = (count_r == {(AW+1){1'b0}});
    assign count        = count_r;
    assign do_push_s    = push && !full;
    assign do_pop_s     = pop && !empty;
    assign rd_ptr_inc_s = rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
    assign head         = mem_r[rd_ptr_r];
    assign head_next    = mem_r[rd_ptr_inc_s];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/foo_call_driver.sv
// Buffers `a` arguments, issues them as foo calls under start/busy, and
// returns tagged results under done/stall with a bounded in-flight count.
module foo_call_driver
    import foo_call_driver_pkg::*;
#(
    parameter int ARG_DEPTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = TAG_W_DEF,
    parameter int ARG_W           = ARG_W_DEF,
    parameter int RET_W           = RET_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             arg_valid,
    output logic             arg_ready,
    input  logic [ARG_W-1:0] arg_data,
    output logic             call_start,
    input  logic             call_busy,
    output logic [ARG_W-1:0] call_a,
    input  logic             ret_done,
    output logic             ret_stall,
    input  logic [RET_W-1:0] ret_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RET_W-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic [7:0]       inflight,
    output logic             idle,
    output logic             err_unexpected
);

    localparam int CW = $clog2(ARG_DEPTH) + 1;

    drv_state_e       state_r;
    drv_state_e       state_nxt_s;
    logic             idle_r;
    logic             call_start_r;
    logic [ARG_W-1:0] call_a_r;
    logic [TAG_W-1:0] issue_tag_r;
    logic [TAG_W-1:0] ret_tag_r;
    logic [7:0]       inflight_r;
    logic [7:0]       inflight_nxt_s;
    logic             res_valid_r;
    logic [RET_W-1:0] res_data_r;
    logic [TAG_W-1:0] res_tag_r;
    logic             err_r;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [ARG_W-1:0] fifo_head_s;
    logic [ARG_W-1:0] fifo_head_next_s;

    logic             push_s;
    logic             call_accept_s;
    logic             call_hold_s;
    logic             ret_accept_s;
    logic             ret_ok_s;
    logic             ret_bad_s;
    logic             res_pop_s;
    logic             avail_s;
    logic [ARG_W-1:0] next_arg_s;
    logic             issue_ok_s;

    foo_drv_fifo #(
        .WIDTH (ARG_W),
        .DEPTH (ARG_DEPTH)
    ) u_arg_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (call_accept_s),
        .wr_data   (arg_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s),
        .head_next (fifo_head_next_s)
    );

    assign arg_ready     = !fifo_full_s;
    assign push_s        = arg_valid && !fifo_full_s;
    assign call_accept_s = call_start_r && !call_busy && !fifo_empty_s;
    assign call_hold_s   = call_start_r && call_busy;
    assign ret_stall     = res_valid_r && !res_ready;
    assign ret_accept_s  = ret_done && !ret_stall;
    assign ret_ok_s      = ret_accept_s && (inflight_r != 8'd0);
    assign ret_bad_s     = ret_accept_s && (inflight_r == 8'd0);
    assign res_pop_s     = res_valid_r && res_ready;

    // Next outstanding count; a simultaneous call and return cancel out.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({call_accept_s, ret_ok_s})
            2'b10:   inflight_nxt_s = inflight_r + 8'd1;
            2'b01:   inflight_nxt_s = inflight_r - 8'd1;
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Enable/drain FSM; IDLE waits until a held call has also been taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable) state_nxt_s = ST_DRAIN;
                else         state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (enable)
                    state_nxt_s = ST_RUN;
                else if ((inflight_r == 8'd0) && !res_valid_r && !call_start_r)
                    state_nxt_s = ST_IDLE;
                else
                    state_nxt_s = ST_DRAIN;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Look past the entry being popped so calls can go out back-to-back.
    always_comb begin
        avail_s    = 1'b0;
        next_arg_s = fifo_head_s;
        if (call_accept_s) begin
            avail_s    = (fifo_count_s > CW'(1));
            next_arg_s = fifo_head_next_s;
        end else begin
            avail_s    = (fifo_count_s != CW'(0));
            next_arg_s = fifo_head_s;
        end
        issue_ok_s = (state_nxt_s == ST_RUN) && avail_s &&
                     (inflight_nxt_s < 8'(MAX_OUTSTANDING));
    end

    // All registered state and outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            idle_r       <= 1'b1;
            call_start_r <= 1'b0;
            call_a_r     <= {ARG_W{1'b0}};
            issue_tag_r  <= {TAG_W{1'b0}};
            ret_tag_r    <= {TAG_W{1'b0}};
            inflight_r   <= 8'd0;
            res_valid_r  <= 1'b0;
            res_data_r   <= {RET_W{1'b0}};
            res_tag_r    <= {TAG_W{1'b0}};
            err_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idle_r     <= (state_nxt_s == ST_IDLE);
            inflight_r <= inflight_nxt_s;

            if (!call_hold_s) begin
                call_start_r <= issue_ok_s;
                if (issue_ok_s) begin
                    call_a_r <= next_arg_s;
                end
            end

            if (call_accept_s) begin
                issue_tag_r <= issue_tag_r + TAG_W'(1);
            end

            if (ret_ok_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= ret_data;
                res_tag_r   <= ret_tag_r;
                ret_tag_r   <= ret_tag_r + TAG_W'(1);
            end else if (res_pop_s) begin
                res_valid_r <= 1'b0;
            end

            if (ret_bad_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign call_start     = call_start_r;
    assign call_a         = call_a_r;
    assign res_valid      = res_valid_r;
    assign res_data       = res_data_r;
    assign res_tag        = res_tag_r;
    assign inflight       = inflight_r;
    assign idle           = idle_r;
    assign err_unexpected = err_r;

endmodule

// File: tb/tb_foo_call_driver.sv
// Directed bench for foo_call_driver: issue, busy hold, outstanding limit,
// result stall, drain to idle, unexpected return and mid-stream reset.
module tb_foo_call_driver;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        arg_valid;
    logic        arg_ready;
    logic [63:0] arg_data;
    logic        call_start;
    logic        call_busy;
    logic [63:0] call_a;
    logic        ret_done;
    logic        ret_stall;
    logic [7:0]  ret_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [7:0]  res_tag;
    logic [7:0]  inflight;
    logic        idle;
    logic        err_unexpected;

    int n_pass;
    int n_total;

    foo_call_driver #(
        .ARG_DEPTH       (8),
        .MAX_OUTSTANDING (4),
        .TAG_W           (8),
        .ARG_W           (64),
        .RET_W           (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .arg_valid      (arg_valid),
        .arg_ready      (arg_ready),
        .arg_data       (arg_data),
        .call_start     (call_start),
        .call_busy      (call_busy),
        .call_a         (call_a),
        .ret_done       (ret_done),
        .ret_stall      (ret_stall),
        .ret_data       (ret_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .res_tag        (res_tag),
        .inflight       (inflight),
        .idle           (idle),
        .err_unexpected (err_unexpected)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total = n_total + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".arg_ready"},  {63'd0, arg_ready},      64'd1);
        check_eq({tag, ".call_start"}, {63'd0, call_start},     64'd0);
        check_eq({tag, ".call_a"},     call_a,                  64'd0);
        check_eq({tag, ".res_valid"},  {63'd0, res_valid},      64'd0);
        check_eq({tag, ".res_data"},   {56'd0, res_data},       64'd0);
        check_eq({tag, ".res_tag"},    {56'd0, res_tag},        64'd0);
        check_eq({tag, ".inflight"},   {56'd0, inflight},       64'd0);
        check_eq({tag, ".idle"},       {63'd0, idle},           64'd1);
        check_eq({tag, ".err"},        {63'd0, err_unexpected}, 64'd0);
    endtask

    initial begin
        int n_calls;
        int waited;
        logic [63:0] first_a;

        n_pass    = 0;
        n_total   = 0;
        reset     = 1'b1;
        enable    = 1'b0;
        arg_valid = 1'b0;
        arg_data  = 64'd0;
        call_busy = 1'b0;
        ret_done  = 1'b0;
        ret_data  = 8'd0;
        res_ready = 1'b0;
        tick();
        tick();
        check_reset_values("rst");

        // Three args go out on three consecutive cycles.
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        arg_valid = 1'b1;
        arg_data  = 64'h10;
        tick();
        arg_data = 64'h20;
        tick();
        check_eq("b2b.start0", {63'd0, call_start}, 64'd1);
        check_eq("b2b.a0", call_a, 64'h10);
        arg_data = 64'h30;
        tick();
        check_eq("b2b.start1", {63'd0, call_start}, 64'd1);
        check_eq("b2b.a1", call_a, 64'h20);
        arg_valid = 1'b0;
        tick();
        check_eq("b2b.start2", {63'd0, call_start}, 64'd1);
        check_eq("b2b.a2", call_a, 64'h30);
        tick();
        check_eq("b2b.stop", {63'd0, call_start}, 64'd0);
        check_eq("b2b.inflight", {56'd0, inflight}, 64'd3);

        // Busy holds a pending call stable.
        call_busy = 1'b1;
        arg_valid = 1'b1;
        arg_data  = 64'h40;
        tick();
        arg_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("busy.start", {63'd0, call_start}, 64'd1);
            check_eq("busy.a", call_a, 64'h40);
            tick();
        end
        check_eq("busy.inflight_held", {56'd0, inflight}, 64'd3);
        call_busy = 1'b0;
        tick();
        check_eq("busy.accept_inflight", {56'd0, inflight}, 64'd4);
        check_eq("busy.start_drop", {63'd0, call_start}, 64'd0);

        // Result register stall: second return waits behind the first.
        ret_done = 1'b1;
        ret_data = 8'hA1;
        check_eq("stall.pre", {63'd0, ret_stall}, 64'd0);
        tick();
        ret_data = 8'hA2;
        check_eq("stall.valid", {63'd0, res_valid}, 64'd1);
        check_eq("stall.data0", {56'd0, res_data}, 64'hA1);
        check_eq("stall.tag0", {56'd0, res_tag}, 64'd0);
        check_eq("stall.ret_stall", {63'd0, ret_stall}, 64'd1);
        tick();
        check_eq("stall.held_data", {56'd0, res_data}, 64'hA1);
        check_eq("stall.held_inflight", {56'd0, inflight}, 64'd3);
        res_ready = 1'b1;
        tick();
        check_eq("stall.data1", {56'd0, res_data}, 64'hA2);
        check_eq("stall.tag1", {56'd0, res_tag}, 64'd1);
        check_eq("stall.valid1", {63'd0, res_valid}, 64'd1);
        ret_done = 1'b0;
        tick();
        check_eq("stall.empty", {63'd0, res_valid}, 64'd0);
        check_eq("stall.inflight", {56'd0, inflight}, 64'd2);

        // Retire the remaining two calls.
        ret_done = 1'b1;
        ret_data = 8'hB1;
        tick();
        ret_data = 8'hB2;
        tick();
        check_eq("retire.tag", {56'd0, res_tag}, 64'd3);
        ret_done = 1'b0;
        tick();
        check_eq("retire.inflight", {56'd0, inflight}, 64'd0);

        // Six args queued: exactly four calls until a return frees a slot.
        n_calls = 0;
        first_a = 64'd0;
        for (int i = 0; i < 12; i++) begin
            arg_valid = (i < 6);
            arg_data  = 64'h50 + 64'(i);
            tick();
            if (call_start) begin
                n_calls = n_calls + 1;
                if (n_calls == 1) first_a = call_a;
            end
        end
        arg_valid = 1'b0;
        check_eq("max.calls", 64'(n_calls), 64'd4);
        check_eq("max.first_a", first_a, 64'h50);
        check_eq("max.start_low", {63'd0, call_start}, 64'd0);
        check_eq("max.inflight", {56'd0, inflight}, 64'd4);
        ret_done = 1'b1;
        ret_data = 8'hC1;
        tick();
        ret_done = 1'b0;
        check_eq("max.reissue", {63'd0, call_start}, 64'd1);
        check_eq("max.reissue_a", call_a, 64'h54);
        check_eq("max.inflight3", {56'd0, inflight}, 64'd3);
        tick();
        check_eq("max.inflight4", {56'd0, inflight}, 64'd4);

        // Drain: no new calls, then IDLE once everything is consumed.
        enable   = 1'b0;
        ret_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ret_data = 8'hE0 + 8'(i);
            tick();
            check_eq("drain.no_call", {63'd0, call_start}, 64'd0);
        end
        ret_done = 1'b0;
        waited = 0;
        while (!idle && waited < 8) begin
            tick();
            waited = waited + 1;
        end
        check_eq("drain.idle", {63'd0, idle}, 64'd1);
        check_eq("drain.inflight", {56'd0, inflight}, 64'd0);
        check_eq("drain.res_valid", {63'd0, res_valid}, 64'd0);

        // The argument left in the FIFO survives the drain.
        enable = 1'b1;
        tick();
        check_eq("resume.start", {63'd0, call_start}, 64'd1);
        check_eq("resume.a", call_a, 64'h55);
        tick();
        ret_done = 1'b1;
        ret_data = 8'hD9;
        tick();
        ret_done = 1'b0;
        check_eq("resume.data", {56'd0, res_data}, 64'hD9);
        check_eq("resume.tag", {56'd0, res_tag}, 64'd9);
        tick();

        // Return with nothing in flight.
        ret_done = 1'b1;
        ret_data = 8'h66;
        tick();
        ret_done = 1'b0;
        check_eq("unexp.err", {63'd0, err_unexpected}, 64'd1);
        check_eq("unexp.no_valid", {63'd0, res_valid}, 64'd0);
        check_eq("unexp.inflight", {56'd0, inflight}, 64'd0);
        tick();
        check_eq("unexp.sticky", {63'd0, err_unexpected}, 64'd1);

        // Reset while a call is pending behind busy.
        call_busy = 1'b1;
        arg_valid = 1'b1;
        arg_data  = 64'h77;
        tick();
        arg_valid = 1'b0;
        tick();
        check_eq("mid.pending", {63'd0, call_start}, 64'd1);
        reset = 1'b1;
        tick();
        check_reset_values("mid");
        reset     = 1'b0;
        call_busy = 1'b0;
        tick();
        tick();
        check_eq("mid.fifo_cleared", {63'd0, call_start}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
